// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipe_pal burst feeder.
package pipe_pkg;

    localparam int unsigned W_DATA        = 32;
    localparam int unsigned W_ADDR        = 16;
    localparam int unsigned W_LEN         = 8;
    localparam int unsigned DEF_ADDR_STEP = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    typedef struct packed {
        logic [W_ADDR-1:0] addr;
        logic [W_DATA-1:0] data;
        logic              last;
    } beat_t;

    localparam int unsigned W_BEAT = $bits(beat_t);

endpackage

// File: rtl/pipe_burst_splitter_if.sv
// Command, input-stream and output-beat handshake bundle for pipe_burst_splitter.
interface pipe_burst_splitter_if;
    import pipe_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [W_ADDR-1:0] cmd_addr;
    logic [W_LEN-1:0]  cmd_len;

    logic              s_valid;
    logic              s_ready;
    logic [W_DATA-1:0] s_data;

    logic              m_valid;
    logic              m_ready;
    logic [W_ADDR-1:0] m_addr;
    logic [W_DATA-1:0] m_data;
    logic              m_last;

    modport slave (
        input  cmd_valid, cmd_addr, cmd_len, s_valid, s_data, m_ready,
        output cmd_ready, s_ready, m_valid, m_addr, m_data, m_last
    );

    modport master (
        output cmd_valid, cmd_addr, cmd_len, s_valid, s_data, m_ready,
        input  cmd_ready, s_ready, m_valid, m_addr, m_data, m_last
    );

endinterface

// File: rtl/pipe_skid_buf.sv
// Two-entry valid/ready register slice (main + skid) with registered in_ready.
module pipe_skid_buf #(
    parameter int unsigned W = 8
) (
    input  logic         i_clk,
    input  logic         resetn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         main_v_q, main_v_d;
    logic         skid_v_q, skid_v_d;
    logic [W-1:0] main_q,   main_d;
    logic [W-1:0] skid_q,   skid_d;
    logic         rdy_q,    rdy_d;
    logic         push,     pop;

    assign in_ready  = rdy_q;
    assign out_valid = main_v_q;
    assign out_data  = main_q;

    // Main always holds the oldest beat; skid only fills when main is stalled.
    always_comb begin
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        main_d   = main_q;
        skid_d   = skid_q;
        push     = in_valid && rdy_q;
        pop      = main_v_q && out_ready;

        if (!main_v_q || pop) begin
            if (skid_v_q) begin
                main_d   = skid_q;
                main_v_d = 1'b1;
                skid_v_d = push;
                if (push) begin
                    skid_d = in_data;
                end
            end else begin
                main_v_d = push;
                if (push) begin
                    main_d = in_data;
                end
            end
        end else if (push) begin
            skid_v_d = 1'b1;
            skid_d   = in_data;
        end

        rdy_d = !(main_v_d && skid_v_d);
    end

    always_ff @(posedge i_clk or negedge resetn) begin
        if (!resetn) begin
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            main_q   <= '0;
            skid_q   <= '0;
            rdy_q    <= 1'b0;
        end else begin
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
            rdy_q    <= rdy_d;
        end
    end

endmodule

// File: rtl/pipe_burst_splitter.sv
// Splits a burst command plus a data stream into address-tagged output beats.
module pipe_burst_splitter
    import pipe_pkg::*;
#(
    parameter int unsigned ADDR_STEP = DEF_ADDR_STEP
) (
    input  logic                  i_clk,
    input  logic                  resetn,
    pipe_burst_splitter_if.slave  bus,
    output logic                  o_busy
);

    state_t            state_q,     state_d;
    logic [W_ADDR-1:0] cur_addr_q,  cur_addr_d;
    logic [W_LEN-1:0]  rem_q,       rem_d;
    logic              cmd_ready_q, cmd_ready_d;

    logic  s_ready_w;
    logic  cmd_hs;
    logic  s_hs;
    logic  buf_in_ready;
    logic  buf_out_valid;
    beat_t push_beat;
    beat_t out_beat;

    assign s_ready_w     = (state_q == BURST) && buf_in_ready;
    assign cmd_hs        = bus.cmd_valid && cmd_ready_q;
    assign s_hs          = bus.s_valid && s_ready_w;

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.s_ready   = s_ready_w;
    assign bus.m_valid   = buf_out_valid;
    assign bus.m_addr    = out_beat.addr;
    assign bus.m_data    = out_beat.data;
    assign bus.m_last    = out_beat.last;
    assign o_busy        = (state_q == BURST) || buf_out_valid;

    // Burst sequencing: address and remaining-beat count advance per accepted word.
    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        rem_d      = rem_q;
        push_beat  = '{addr: cur_addr_q, data: bus.s_data, last: (rem_q == '0)};

        case (state_q)
            IDLE: begin
                if (cmd_hs) begin
                    cur_addr_d = bus.cmd_addr;
                    rem_d      = bus.cmd_len;
                    state_d    = BURST;
                end
            end
            BURST: begin
                if (s_hs) begin
                    cur_addr_d = cur_addr_q + W_ADDR'(ADDR_STEP);
                    rem_d      = rem_q - W_LEN'(1);
                    if (rem_q == '0) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge i_clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            rem_q       <= '0;
            cmd_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            rem_q       <= rem_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    pipe_skid_buf #(
        .W (W_BEAT)
    ) u_skid (
        .i_clk     (i_clk),
        .resetn    (resetn),
        .in_valid  (s_hs),
        .in_ready  (buf_in_ready),
        .in_data   (push_beat),
        .out_valid (buf_out_valid),
        .out_ready (bus.m_ready),
        .out_data  (out_beat)
    );

endmodule
